or_gate_sweeper: RTL
====================

// Module: or_gate_sweeper
// PURPOSE
//  Self-running stimulus/check stage wrapped around the 2-input OR gate.
//  - Drives the gate inputs a/b through all four input vectors.
//  - Samples the gate output y and compares it against a|b.
//  - Counts mismatches and reports pass/fail with a done pulse.
//  - Replaces hand-sequenced delays, so the gate can be exercised inside a clocked system.
// PARAMETERS
//  SETTLE_CYCLES  1  cycles a/b are held before y is sampled; legal range >=1
//  REPEAT         1  number of full 4-vector sweeps per start; legal range >=1
//  ERR_W          8  width of err_count; the count saturates at 2^ERR_W-1
// PORTS
//  clk         in   1      clock; all state changes on the rising edge
//  rst         in   1      asynchronous, active-high reset
//  start       in   1      begins a run; sampled only in IDLE
//  y           in   1      output of the gate under test
//  a           out  1      gate input A (registered)
//  b           out  1      gate input B (registered)
//  busy        out  1      high in DRIVE and SAMPLE
//  done        out  1      one-cycle pulse at the end of a run
//  pass        out  1      1 if the last run had zero mismatches
//  err_count   out  ERR_W  mismatch count of the last or current run
//  first_fail  out  2      vector index of the first mismatch; valid when pass=0 after done
// BEHAVIOUR
//  Reset values: state=IDLE; a=0, b=0, busy=0, done=0, pass=0, err_count=0, first_fail=0.
//    - Reset acts immediately and may arrive mid-run.
//    - After reset release, the next start restarts at idx 0, sweep 0.
//  Vector order (idx: a,b): 0:(1,0)  1:(0,1)  2:(1,1)  3:(0,0).
//  States: IDLE, DRIVE, SAMPLE, DONE.
//  IDLE
//    - If start=1 at the edge: enter DRIVE, idx=0, sweep=0, settle=0.
//    - On that same edge: clear err_count, first_fail and pass; drive a/b from vector 0.
//  DRIVE
//    - a/b are held stable.
//    - Leave for SAMPLE after SETTLE_CYCLES cycles in DRIVE.
//  SAMPLE (1 cycle)
//    - a/b are still held.
//    - Mismatch: y !== (a|b). X/Z on y counts as a mismatch.
//    - On a mismatch, err_count increments, saturating at all-ones.
//    - On the first mismatch of the run, first_fail is loaded with idx.
//    - If idx=3 and sweep=REPEAT-1: go to DONE.
//    - Otherwise idx wraps 3->0 (sweep++ on the wrap), a/b load the next vector, and the FSM returns to DRIVE.
//  DONE (1 cycle)
//    - done=1 and pass=(err_count==0), including the final sample.
//    - a/b return to 0; next state is IDLE.
//  Latency: done is high exactly 4*REPEAT*(SETTLE_CYCLES+1)+1 cycles after the edge that accepted start.
//  start while busy or in DONE: ignored. There is no queueing and no restart.
//  start held high continuously: a new run begins on the first IDLE edge after DONE.
//  pass, err_count and first_fail hold their values until the next accepted start.
//  Counter widths:
//    - idx: 2 bits.
//    - sweep: $clog2(REPEAT+1) bits.
//    - settle: $clog2(SETTLE_CYCLES+1) bits.
// TESTING
//  1. Ideal OR model, S=1, R=1, one start pulse
//     -> a/b sequence is 10,01,11,00, each held 2 cycles.
//     -> done at +9 cycles; pass=1, err_count=0.
//  2. Faulty gate y=a&b, S=1, R=1
//     -> mismatches at idx 0 and 1; err_count=2, pass=0, first_fail=0.
//  3. Stuck-at-1 y, S=2, R=3
//     -> only vector 3 fails in each sweep; err_count=3, first_fail=3.
//     -> done at +37 cycles.
//  4. start re-pulsed while busy, then held high
//     -> exactly one done per run.
//     -> the second run clears err_count on acceptance and restarts at idx 0.
//  5. rst asserted during the SAMPLE of idx 2
//     -> a=b=busy=0 and err_count=0 immediately, without waiting for a clock edge.
//     -> after release, the next start drives vector (1,0) first.
//  6. ERR_W=2, R=2, y=~(a|b)
//     -> 8 mismatches; err_count saturates at 3, pass=0, first_fail=0.

Source files
------------

// File: rtl/or_gate_sweeper.sv
// Clocked stimulus/check wrapper for a 2-input OR gate.
// It sweeps a/b through four vectors, compares y with a|b, and reports the result with a done pulse.
module or_gate_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned REPEAT        = 1,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             y,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       first_fail
);

    localparam int SW_W = $clog2(REPEAT + 1);
    localparam int ST_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t            state, state_n;
    logic [1:0]        idx, idx_n;
    logic [SW_W-1:0]   sweep, sweep_n;
    logic [ST_W-1:0]   settle, settle_n;
    logic [1:0]        ab_n;
    logic [ERR_W-1:0]  err_n;
    logic [1:0]        ff_n;
    logic              pass_n, done_n, mismatch;

    // Vector order puts (0,0) last, so a/b are already low when the run ends.
    function automatic logic [1:0] vec(input logic [1:0] i);
        case (i)
            2'd0:    vec = 2'b10;
            2'd1:    vec = 2'b01;
            2'd2:    vec = 2'b11;
            default: vec = 2'b00;
        endcase
    endfunction

    // Case inequality makes an X or Z on y count as a mismatch.
    assign mismatch = (y !== (a | b));
    assign busy     = (state == DRIVE) || (state == SAMPLE);

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case infers a latch.
        state_n  = state;
        idx_n    = idx;
        sweep_n  = sweep;
        settle_n = settle;
        ab_n     = {a, b};
        err_n    = err_count;
        ff_n     = first_fail;
        pass_n   = pass;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n  = DRIVE;
                    idx_n    = 2'd0;
                    sweep_n  = '0;
                    settle_n = '0;
                    err_n    = '0;
                    ff_n     = 2'd0;
                    pass_n   = 1'b0;
                    ab_n     = vec(2'd0);
                end
            end
            DRIVE: begin
                if (settle == ST_W'(SETTLE_CYCLES - 1)) begin
                    state_n  = SAMPLE;
                    settle_n = '0;
                end else begin
                    settle_n = settle + 1'b1;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    if (err_count != {ERR_W{1'b1}}) err_n = err_count + 1'b1;
                    // Saturation keeps the count non-zero, so zero means "no earlier failure".
                    if (err_count == '0) ff_n = idx;
                end
                if (idx == 2'd3 && sweep == SW_W'(REPEAT - 1)) begin
                    state_n = DONE;
                end else begin
                    idx_n   = idx + 2'd1;
                    ab_n    = vec(idx + 2'd1);
                    state_n = DRIVE;
                    if (idx == 2'd3) sweep_n = sweep + 1'b1;
                end
            end
            DONE: begin
                done_n  = 1'b1;
                pass_n  = (err_count == '0);
                ab_n    = 2'b00;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 2'd0;
            sweep      <= '0;
            settle     <= '0;
            a          <= 1'b0;
            b          <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= 2'd0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            sweep      <= sweep_n;
            settle     <= settle_n;
            {a, b}     <= ab_n;
            done       <= done_n;
            pass       <= pass_n;
            err_count  <= err_n;
            first_fail <= ff_n;
        end
    end

endmodule
